// File: rtl/cam_pkg.sv
// Shared types and constants for the camera capture window block.
package cam_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOF = 2'd1,
        ACTIVE   = 2'd2
    } state_t;

    localparam int DEFAULT_STRIDE = 174;

    function automatic bit bpp_legal(input int bpp);
        return (bpp == 1) || (bpp == 2);
    endfunction

endpackage

// File: rtl/cam_capture_win_if.sv
// Pixel output bus towards the frame-buffer write port.
interface cam_capture_win_if #(
    parameter int PIX_W   = 16,
    parameter int COORD_W = 10,
    parameter int ADDR_W  = 19
);
    logic               pix_valid;
    logic [PIX_W-1:0]   pix_data;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic [ADDR_W-1:0]  mem_addr;

    modport master (
        output pix_valid, pix_data, pix_x, pix_y, mem_addr
    );

    modport slave (
        input pix_valid, pix_data, pix_x, pix_y, mem_addr
    );
endinterface

// File: rtl/cam_byte_pack.sv
// Byte phase tracking and byte-to-pixel assembly; pix_done marks the last byte of a pixel.
module cam_byte_pack #(
    parameter int BYTES_PER_PIX = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         swap,
    input  logic [7:0]                   data,
    output logic                         phase,
    output logic                         pix_done,
    output logic [8*BYTES_PER_PIX-1:0]   pix_data
);

    if (BYTES_PER_PIX == 2) begin : g_two
        logic       phase_r;
        logic [7:0] hold_r;

        // Phase toggles per accepted byte and drops to 0 whenever no byte is accepted
        always_ff @(posedge clk) begin
            if (!reset) begin
                phase_r <= 1'b0;
                hold_r  <= 8'h00;
            end else if (en) begin
                phase_r <= ~phase_r;
                if (!phase_r) begin
                    hold_r <= data;
                end
            end else begin
                phase_r <= 1'b0;
            end
        end

        // Second byte completes the pixel; swap selects which byte lands in the high half
        always_comb begin
            pix_done = en & phase_r;
            if (swap) begin
                pix_data = {hold_r, data};
            end else begin
                pix_data = {data, hold_r};
            end
        end

        assign phase = phase_r;
    end else begin : g_one
        assign phase    = 1'b0;
        assign pix_done = en;
        assign pix_data = data;
    end

endmodule

// File: rtl/cam_capture_win.sv
// Camera capture with per-frame arming, crop window, 2:1 decimation and strided addressing.
module cam_capture_win
    import cam_pkg::*;
#(
    parameter int BYTES_PER_PIX = 2,
    parameter int H_ACTIVE      = 640,
    parameter int COORD_W       = 10,
    parameter int ADDR_W        = 19,
    parameter int STRIDE        = DEFAULT_STRIDE,
    parameter int BASE_ADDR     = 0
) (
    input  logic               pclk,
    input  logic               reset,
    input  logic               vsync,
    input  logic               href,
    input  logic [7:0]         data,
    input  logic               arm,
    input  logic               continuous,
    input  logic               decim,
    input  logic               swap_bytes,
    input  logic [COORD_W-1:0] win_x0,
    input  logic [COORD_W-1:0] win_x1,
    input  logic [COORD_W-1:0] win_y0,
    input  logic [COORD_W-1:0] win_y1,
    cam_capture_win_if.master  pix,
    output logic               busy,
    output logic               frame_start,
    output logic               frame_done,
    output logic [15:0]        frame_cnt,
    output logic               line_err
);

    localparam int PIX_W = 8 * BYTES_PER_PIX;

    if (!bpp_legal(BYTES_PER_PIX)) begin : g_bpp_check
        $error("cam_capture_win: BYTES_PER_PIX must be 1 or 2");
    end

    state_t             state_r, state_next_s;
    logic               vsync_d1_r, vsync_d2_r, href_d1_r, hv_d_r;
    logic [7:0]         data_d1_r;
    logic               cont_r, decim_r;
    logic [COORD_W-1:0] win_x0_r, win_x1_r, win_y0_r, win_y1_r;
    logic [COORD_W-1:0] sx_r, sy_r, out_x_r, out_y_r;
    logic [ADDR_W-1:0]  line_base_r;
    logic               line_hit_r;

    logic               hv_s, vs_fall_s, vs_rise_s, active_s, en_s, href_fall_s;
    logic               sof_s, eof_s, arm_ok_s;
    logic               pix_done_s, phase_s, in_win_s, emit_s, line_bad_s;
    logic [PIX_W-1:0]   pix_word_s;
    logic [COORD_W-1:0] sx_inc_s, sy_inc_s;

    // Camera pins are registered once; all decisions work on this sampled copy
    always_ff @(posedge pclk) begin
        if (!reset) begin
            vsync_d1_r <= 1'b0;
            vsync_d2_r <= 1'b0;
            href_d1_r  <= 1'b0;
            data_d1_r  <= 8'h00;
            hv_d_r     <= 1'b0;
        end else begin
            vsync_d1_r <= vsync;
            vsync_d2_r <= vsync_d1_r;
            href_d1_r  <= href;
            data_d1_r  <= data;
            hv_d_r     <= hv_s;
        end
    end

    // href counts only outside vsync blanking, so a vsync rise mid-line looks like a line end
    always_comb begin
        hv_s        = href_d1_r & ~vsync_d1_r;
        vs_fall_s   = vsync_d2_r & ~vsync_d1_r;
        vs_rise_s   = ~vsync_d2_r & vsync_d1_r;
        active_s    = (state_r == ACTIVE);
        en_s        = active_s & hv_s;
        href_fall_s = active_s & hv_d_r & ~hv_s;
        arm_ok_s    = (state_r == IDLE) & arm;
    end

    cam_byte_pack #(
        .BYTES_PER_PIX (BYTES_PER_PIX)
    ) u_pack (
        .clk      (pclk),
        .reset    (reset),
        .en       (en_s),
        .swap     (swap_bytes),
        .data     (data_d1_r),
        .phase    (phase_s),
        .pix_done (pix_done_s),
        .pix_data (pix_word_s)
    );

    // Window/decimation decision and line check on the current source coordinates
    always_comb begin
        in_win_s = (sx_r >= win_x0_r) && (sx_r <= win_x1_r) &&
                   (sy_r >= win_y0_r) && (sy_r <= win_y1_r);
        if (decim_r) begin
            emit_s = pix_done_s & in_win_s & ~sx_r[0] & ~sy_r[0];
        end else begin
            emit_s = pix_done_s & in_win_s;
        end
        line_bad_s = href_fall_s & (phase_s | (sx_r != COORD_W'(H_ACTIVE)));
        sx_inc_s   = (&sx_r) ? sx_r : sx_r + COORD_W'(1);
        sy_inc_s   = (&sy_r) ? sy_r : sy_r + COORD_W'(1);
    end

    // Next-state logic for the frame arming sequence
    always_comb begin
        state_next_s = state_r;
        sof_s        = 1'b0;
        eof_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (arm) begin
                    state_next_s = WAIT_SOF;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT_SOF: begin
                if (vs_fall_s) begin
                    state_next_s = ACTIVE;
                    sof_s        = 1'b1;
                end else begin
                    state_next_s = WAIT_SOF;
                end
            end
            ACTIVE: begin
                if (vs_rise_s) begin
                    eof_s = 1'b1;
                    if (cont_r) begin
                        state_next_s = WAIT_SOF;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = ACTIVE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge pclk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Frame configuration capture, source/output counters and line base address
    always_ff @(posedge pclk) begin
        if (!reset) begin
            cont_r      <= 1'b0;
            decim_r     <= 1'b0;
            win_x0_r    <= '0;
            win_x1_r    <= '0;
            win_y0_r    <= '0;
            win_y1_r    <= '0;
            sx_r        <= '0;
            sy_r        <= '0;
            out_x_r     <= '0;
            out_y_r     <= '0;
            line_base_r <= '0;
            line_hit_r  <= 1'b0;
        end else if (sof_s) begin
            cont_r      <= continuous;
            decim_r     <= decim;
            win_x0_r    <= win_x0;
            win_x1_r    <= win_x1;
            win_y0_r    <= win_y0;
            win_y1_r    <= win_y1;
            sx_r        <= '0;
            sy_r        <= '0;
            out_x_r     <= '0;
            out_y_r     <= '0;
            line_base_r <= ADDR_W'(BASE_ADDR);
            line_hit_r  <= 1'b0;
        end else if (href_fall_s) begin
            sx_r       <= '0;
            sy_r       <= sy_inc_s;
            out_x_r    <= '0;
            line_hit_r <= 1'b0;
            if (line_hit_r) begin
                out_y_r     <= out_y_r + COORD_W'(1);
                line_base_r <= line_base_r + ADDR_W'(STRIDE);
            end
        end else if (pix_done_s) begin
            sx_r <= sx_inc_s;
            if (emit_s) begin
                out_x_r    <= out_x_r + COORD_W'(1);
                line_hit_r <= 1'b1;
            end
        end
    end

    // Pixel output bus; all fields load together on an emitted pixel
    always_ff @(posedge pclk) begin
        if (!reset) begin
            pix.pix_valid <= 1'b0;
            pix.pix_data  <= '0;
            pix.pix_x     <= '0;
            pix.pix_y     <= '0;
            pix.mem_addr  <= '0;
        end else if (emit_s) begin
            pix.pix_valid <= 1'b1;
            pix.pix_data  <= pix_word_s;
            pix.pix_x     <= out_x_r;
            pix.pix_y     <= out_y_r;
            pix.mem_addr  <= line_base_r + ADDR_W'(out_x_r);
        end else begin
            pix.pix_valid <= 1'b0;
        end
    end

    // Status outputs: busy, frame pulses, frame counter and sticky line error
    always_ff @(posedge pclk) begin
        if (!reset) begin
            busy        <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_cnt   <= 16'd0;
            line_err    <= 1'b0;
        end else begin
            busy        <= (state_next_s != IDLE);
            frame_start <= sof_s;
            frame_done  <= eof_s;
            if (eof_s) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (arm_ok_s) begin
                line_err <= 1'b0;
            end else if (line_bad_s) begin
                line_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cam_capture_win.sv
// Directed bench for cam_capture_win with a frame-level pixel model and per-pixel scoreboard.
module tb_cam_capture_win;
    import cam_pkg::*;

    localparam int COORD_W = 10;
    localparam int ADDR_W  = 19;
    localparam int PIX_W   = 16;

    typedef struct {
        logic [31:0] data;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] addr;
    } pix_t;

    logic               pclk = 1'b0;
    logic               reset = 1'b0;
    logic               vsync = 1'b1;
    logic               href = 1'b0;
    logic [7:0]         data = 8'h00;
    logic               arm = 1'b0;
    logic               continuous = 1'b0;
    logic               decim = 1'b0;
    logic               swap_bytes = 1'b0;
    logic [COORD_W-1:0] win_x0 = '0, win_x1 = '0, win_y0 = '0, win_y1 = '0;
    logic               busy, frame_start, frame_done, line_err;
    logic [15:0]        frame_cnt;

    int   checks = 0;
    int   errors = 0;
    int   fs_cnt = 0;
    int   fd_cnt = 0;
    int   exp_frames = 0;
    pix_t exp_q[$];
    pix_t obs_q[$];

    cam_capture_win_if #(.PIX_W(PIX_W), .COORD_W(COORD_W), .ADDR_W(ADDR_W)) pix_if ();

    cam_capture_win #(
        .BYTES_PER_PIX (2),
        .H_ACTIVE      (640),
        .COORD_W       (COORD_W),
        .ADDR_W        (ADDR_W),
        .STRIDE        (174),
        .BASE_ADDR     (0)
    ) dut (
        .pclk        (pclk),
        .reset       (reset),
        .vsync       (vsync),
        .href        (href),
        .data        (data),
        .arm         (arm),
        .continuous  (continuous),
        .decim       (decim),
        .swap_bytes  (swap_bytes),
        .win_x0      (win_x0),
        .win_x1      (win_x1),
        .win_y0      (win_y0),
        .win_y1      (win_y1),
        .pix         (pix_if),
        .busy        (busy),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt),
        .line_err    (line_err)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input bit vary, input int l, input int b);
        if (!vary) return (b % 2 == 0) ? 8'h11 : 8'h22;
        return 8'((l * 37 + b * 5 + 3) & 255);
    endfunction

    // Model: walk the source frame and list every pixel the window/decimation rules keep
    task automatic build_expected(input int nlines, input int nbytes, input bit vary);
        int   oy;
        int   ox;
        pix_t p;
        oy = 0;
        for (int l = 0; l < nlines; l++) begin
            ox = 0;
            for (int k = 0; k < nbytes / 2; k++) begin
                if (k >= int'(win_x0) && k <= int'(win_x1) && l >= int'(win_y0) && l <= int'(win_y1) &&
                    (!decim || (k % 2 == 0 && l % 2 == 0))) begin
                    p.data = swap_bytes ? {16'h0, byte_at(vary, l, 2*k), byte_at(vary, l, 2*k+1)}
                                        : {16'h0, byte_at(vary, l, 2*k+1), byte_at(vary, l, 2*k)};
                    p.x    = ox;
                    p.y    = oy;
                    p.addr = (oy * 174 + ox) % (1 << ADDR_W);
                    exp_q.push_back(p);
                    ox++;
                end
            end
            if (ox > 0) oy++;
        end
    endtask

    // Scoreboard: every valid pixel is matched against the model in order
    always @(negedge pclk) begin
        pix_t e;
        pix_t o;
        if (reset && pix_if.pix_valid) begin
            o.data = 32'(pix_if.pix_data);
            o.x    = 32'(pix_if.pix_x);
            o.y    = 32'(pix_if.pix_y);
            o.addr = 32'(pix_if.mem_addr);
            obs_q.push_back(o);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_pix actual x=%0d y=%0d expected no pixel", o.x, o.y);
            end else begin
                e = exp_q.pop_front();
                check("pix_data", o.data, e.data);
                check("pix_x", o.x, e.x);
                check("pix_y", o.y, e.y);
                check("mem_addr", o.addr, e.addr);
            end
        end
        if (frame_start) fs_cnt++;
        if (frame_done) fd_cnt++;
    end

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    task automatic pulse_arm;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic lead_in;
        vsync = 1'b1;
        repeat (4) tick();
        href = 1'b1;
        data = 8'hEE;
        repeat (3) tick();
        href = 1'b0;
        repeat (4) tick();
        vsync = 1'b0;
        repeat (6) tick();
    endtask

    task automatic drive_line(input int l, input int nbytes, input bit vary);
        href = 1'b1;
        for (int b = 0; b < nbytes; b++) begin
            data = byte_at(vary, l, b);
            tick();
        end
        href = 1'b0;
        repeat (8) tick();
    endtask

    task automatic tail;
        vsync = 1'b1;
        repeat (6) tick();
    endtask

    task automatic run_frame(input int nlines, input int nbytes, input bit vary);
        build_expected(nlines, nbytes, vary);
        lead_in();
        for (int l = 0; l < nlines; l++) drive_line(l, nbytes, vary);
        tail();
        exp_frames++;
    endtask

    task automatic set_win(input int x0, input int x1, input int y0, input int y1);
        win_x0 = COORD_W'(x0);
        win_x1 = COORD_W'(x1);
        win_y0 = COORD_W'(y0);
        win_y1 = COORD_W'(y1);
    endtask

    initial begin
        int f0;
        int s0;
        int cnt;

        repeat (3) tick();
        check("rst_pix_valid", 32'(pix_if.pix_valid), 32'd0);
        check("rst_mem_addr", 32'(pix_if.mem_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_line_err", 32'(line_err), 32'd0);
        reset = 1'b1;
        tick();

        // Full frame, normal byte order
        set_win(0, 639, 0, 479);
        obs_q.delete();
        f0 = fd_cnt;
        build_expected(4, 1280, 1'b0);
        check("model_full_size", 32'(exp_q.size()), 32'd2560);
        exp_q.delete();
        pulse_arm();
        run_frame(4, 1280, 1'b0);
        repeat (4) tick();
        check("full_left", 32'(exp_q.size()), 32'd0);
        check("full_count", 32'(obs_q.size()), 32'd2560);
        check("full_data0", obs_q[0].data, 32'h2211);
        check("full_l1p0_addr", obs_q[640].addr, 32'd174);
        for (int y = 0; y < 4; y++) begin
            cnt = 0;
            foreach (obs_q[i]) if (obs_q[i].y == 32'(y)) cnt++;
            check("full_line_pix", 32'(cnt), 32'd640);
        end
        check("full_line_err", 32'(line_err), 32'd0);
        check("full_done_once", 32'(fd_cnt - f0), 32'd1);
        check("full_frame_cnt", 32'(frame_cnt), 32'd1);
        check("full_busy", 32'(busy), 32'd0);
        check("full_idle", 32'(dut.state_r), 32'(IDLE));

        // Same stimulus with swapped byte order
        swap_bytes = 1'b1;
        obs_q.delete();
        pulse_arm();
        run_frame(4, 1280, 1'b0);
        repeat (4) tick();
        check("swap_count", 32'(obs_q.size()), 32'd2560);
        check("swap_data0", obs_q[0].data, 32'h1122);
        swap_bytes = 1'b0;

        // Crop window x 10..13, y 2..3 with varying data
        set_win(10, 13, 2, 3);
        obs_q.delete();
        pulse_arm();
        run_frame(4, 1280, 1'b1);
        repeat (4) tick();
        check("win_count", 32'(obs_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check("win_addr", obs_q[i].addr, (i < 4) ? 32'(i) : 32'(170 + i));
            check("win_x", obs_q[i].x, 32'(i % 4));
            check("win_y", obs_q[i].y, 32'(i / 4));
        end

        // 2:1 decimation over the full window
        set_win(0, 639, 0, 479);
        decim = 1'b1;
        obs_q.delete();
        pulse_arm();
        run_frame(4, 1280, 1'b1);
        repeat (4) tick();
        decim = 1'b0;
        check("dec_count", 32'(obs_q.size()), 32'd640);
        check("dec_y_first", obs_q[319].y, 32'd0);
        check("dec_y_second", obs_q[320].y, 32'd1);
        check("dec_last_x", obs_q[639].x, 32'd319);
        check("dec_last_addr", obs_q[639].addr, 32'd493);

        // Reversed window: nothing emitted, frame still completes
        set_win(20, 10, 0, 479);
        obs_q.delete();
        f0 = fd_cnt;
        pulse_arm();
        run_frame(2, 1280, 1'b0);
        repeat (4) tick();
        check("rev_count", 32'(obs_q.size()), 32'd0);
        check("rev_done", 32'(fd_cnt - f0), 32'd1);
        check("rev_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

        // Continuous capture over three frames
        set_win(0, 639, 0, 479);
        continuous = 1'b1;
        f0 = fd_cnt;
        s0 = fs_cnt;
        pulse_arm();
        run_frame(2, 1280, 1'b0);
        check("cont_busy_between", 32'(busy), 32'd1);
        run_frame(2, 1280, 1'b0);
        continuous = 1'b0;
        run_frame(2, 1280, 1'b0);
        repeat (4) tick();
        check("cont_starts", 32'(fs_cnt - s0), 32'd3);
        check("cont_dones", 32'(fd_cnt - f0), 32'd3);
        check("cont_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
        check("cont_busy_end", 32'(busy), 32'd0);
        check("cont_left", 32'(exp_q.size()), 32'd0);

        // Odd-length line: sticky error until the next arm
        pulse_arm();
        build_expected(1, 1281, 1'b0);
        lead_in();
        drive_line(0, 1281, 1'b0);
        check("err_at_fall", 32'(line_err), 32'd1);
        tail();
        exp_frames++;
        repeat (20) tick();
        check("err_sticky", 32'(line_err), 32'd1);
        check("err_left", 32'(exp_q.size()), 32'd0);
        check("err_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
        pulse_arm();
        check("err_cleared", 32'(line_err), 32'd0);

        // Reset in the middle of frame 2 of a continuous run
        continuous = 1'b1;
        run_frame(2, 1280, 1'b0);
        check("rr_busy_f1", 32'(busy), 32'd1);
        build_expected(1, 300, 1'b0);
        lead_in();
        drive_line(0, 300, 1'b0);
        f0 = fd_cnt;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rr_idle", 32'(dut.state_r), 32'(IDLE));
        check("rr_busy", 32'(busy), 32'd0);
        check("rr_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rr_left", 32'(exp_q.size()), 32'd0);
        tail();
        repeat (10) tick();
        check("rr_no_done", 32'(fd_cnt - f0), 32'd0);
        check("rr_pix_valid", 32'(pix_if.pix_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_capture_win.md
Name: cam_capture_win

Overview:
- Parametrised successor to the OV7670 byte-pair capture block.
- Assembles camera bytes into pixels of 1 or 2 bytes, applies a runtime crop window and optional 2:1 decimation, and generates strided memory addresses without a multiplier.
- Arms per frame in single-shot or continuous mode and reports frame and line errors.
- Sits between the camera pins (pclk domain) and the frame-buffer write port.

Parameters:
- BYTES_PER_PIX, 2, bytes per pixel (1 or 2); PIX_W = 8*BYTES_PER_PIX.
- H_ACTIVE, 640, expected pixels per href line; used for line error check.
- COORD_W, 10, width of x/y coordinates and window inputs.
- ADDR_W, 19, memory address width.
- STRIDE, 174, address increment per emitted output line.
- BASE_ADDR, 0, address of output pixel (0,0).

Ports:
- pclk  in  1  camera pixel clock; the only clock.
- reset  in  1  synchronous, active-low reset.
- vsync  in  1  camera vsync, high = blanking/frame boundary.
- href  in  1  camera href, high = active line bytes.
- data  in  8  camera data byte.
- arm  in  1  1-cycle pulse; requests capture starting at the next frame.
- continuous  in  1  1 = re-arm automatically after each frame; sampled at frame start.
- decim  in  1  1 = keep only even source x and even source y; sampled at frame start.
- swap_bytes  in  1  0 = first byte goes to pix_data[7:0]; 1 = first byte goes to [15:8]. Ignored when BYTES_PER_PIX=1.
- win_x0, win_x1, win_y0, win_y1  in  COORD_W each  inclusive crop window in source coordinates; sampled at frame start.
- pix_valid  out  1  1-cycle strobe; pix_data, pix_x, pix_y and mem_addr are valid.
- pix_data  out  PIX_W  assembled pixel.
- pix_x, pix_y  out  COORD_W each  output (cropped, decimated) coordinates.
- mem_addr  out  ADDR_W  BASE_ADDR + pix_y*STRIDE + pix_x.
- busy  out  1  high in WAIT_SOF or ACTIVE.
- frame_start  out  1  1-cycle pulse on entry to ACTIVE.
- frame_done  out  1  1-cycle pulse at end of a captured frame.
- frame_cnt  out  16  count of completed frames; wraps at 2^16.
- line_err  out  1  sticky; set on a bad line; cleared by arm.

Behaviour:
- Reset (reset=0 at a pclk edge):
  - state = IDLE.
  - All outputs, counters, byte phase and the sampled mode/window registers are 0.
- States:
  - IDLE: on arm, go to WAIT_SOF.
  - WAIT_SOF: on a vsync falling edge (registered vsync 1→0), sample the mode and window inputs, clear counters, pulse frame_start, go to ACTIVE.
  - ACTIVE: on a vsync rising edge, pulse frame_done, increment frame_cnt, then go to WAIT_SOF if continuous_s else IDLE.
  - arm received in any state other than IDLE is ignored.
- Source counters (ACTIVE only):
  - sx counts completed pixels within a line; sy counts href falling edges.
  - Both start at 0 for each frame. sx resets to 0 on each href falling edge.
- Byte phase:
  - Toggles on each href-high cycle; forced to 0 while href is low.
  - For BYTES_PER_PIX=1, every href-high byte is a complete pixel.
- Emission: a pixel completes at its last byte. It is emitted when all of the following hold:
  - win_x0_s ≤ sx ≤ win_x1_s and win_y0_s ≤ sy ≤ win_y1_s;
  - if decim_s = 1, sx[0]=0 and sy[0]=0.
- Output latency and coordinates:
  - pix_valid goes high exactly 1 pclk after the edge that samples the completing byte. All output registers update together.
  - Output x increments per emitted pixel and resets at each line.
  - Output y increments after any line in which ≥1 pixel was emitted.
- Address generation:
  - line_base starts at BASE_ADDR and adds STRIDE on each output-y increment; no multiplier.
  - mem_addr = line_base + out_x, truncated to ADDR_W (wrap-around allowed, not flagged).
- Line check: at each href falling edge in ACTIVE, line_err is set if either holds:
  - byte phase ≠ 0 (odd trailing byte, which is discarded);
  - sx ≠ H_ACTIVE.
- Boundary conditions:
  - href high while vsync is high: ignored, with no counting.
  - win_x0 > win_x1 or win_y0 > win_y1: no pixels emitted; frame_done still pulses.
  - sx/sy saturate at all-ones and never wrap.
  - A vsync rising edge mid-line ends the frame: a pending half-pixel is discarded and line_err is set.
  - reset asserted mid-frame: immediate IDLE; no frame_done.
- All outputs are registered.

Decomposition:
- Package cam_pkg:
  - state enum (IDLE, WAIT_SOF, ACTIVE);
  - BYTES_PER_PIX legal-value check;
  - the default value of the STRIDE constant (174).
- One sub-module, cam_byte_pack: byte phase, byte swap and pixel-complete strobe; parametrised by BYTES_PER_PIX.
- Top level holds the FSM, counters, window/decimation logic and address generator.

Test Plan:
- Full frame, BYTES_PER_PIX=2, window 0..639 × 0..479, decim=0, 4 lines of bytes 0x11,0x22 repeating:
  - 640 pix_valid per line; pix_data=0x2211;
  - mem_addr of line 1 pixel 0 = 174;
  - line_err=0; frame_done once; frame_cnt=1; returns to IDLE.
- swap_bytes=1, same stimulus: pix_data=0x1122.
- Window x 10..13, y 2..3, decim=0:
  - exactly 8 pixels at (0..3,0) and (0..3,1);
  - mem_addr 0..3 then 174..177.
- decim=1, full window, 4-line frame:
  - 320 pixels on source lines 0 and 2 only;
  - pix_y 0,1; last mem_addr = 174+319 = 493.
- Line of 1281 bytes: line_err=1 at href fall; it stays 1 until the next arm.
- continuous=1 over 3 frames: 3 frame_start and 3 frame_done pulses, frame_cnt=3. Reset mid-frame 2 of a repeat run: state IDLE, busy=0, no frame_done.
